// File: rtl/spi_txn_arbiter.sv
// ---------------------------------------------------------------------------
// spi_txn_arbiter
// Round-robin arbiter and sequencer that shares one 8-bit SPI master driver
// among NUM_REQ requesters. A winning request gets a one-hot active-low chip
// select, a one-cycle start pulse with its tx byte to the driver, completion
// tracking on the driver's enable line and the received byte returned with a
// done pulse. A watchdog aborts transactions whose driver never completes.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_req             per-requester level request, held until ack
//   i_req_data        tx bytes, requester i at [8i+7:8i]
//   o_ack             one-cycle pulse, request captured
//   o_done            one-cycle pulse, transaction finished, o_rsp_data valid
//   o_err             one-cycle pulse with o_done on watchdog abort
//   o_rsp_data        received byte, held until the next done
//   o_busy            high whenever the sequencer is not idle
//   o_cs_n            chip selects, active low, at most one low
//   o_drv_start       start pulse to the SPI driver
//   o_drv_data        tx byte to the driver
//   i_drv_en          driver enable/busy
//   i_drv_rdata       driver received byte, valid when i_drv_en falls
// ---------------------------------------------------------------------------
module spi_txn_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    output logic [NUM_REQ-1:0]   o_ack,
    output logic [NUM_REQ-1:0]   o_done,
    output logic                 o_err,
    output logic [7:0]           o_rsp_data,
    output logic                 o_busy,
    output logic [NUM_REQ-1:0]   o_cs_n,
    output logic                 o_drv_start,
    output logic [7:0]           o_drv_data,
    input  logic                 i_drv_en,
    input  logic [7:0]           i_drv_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(WDOG_CYCLES);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WDOG_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_EN,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_idx;
    logic [NUM_REQ-1:0]   r_ack;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_err;
    logic                 r_busy;
    logic                 r_drv_start;
    logic [NUM_REQ-1:0]   r_cs_n;
    logic [7:0]           r_drv_data;
    logic [7:0]           r_rsp_data;
    logic [WD_W-1:0]      r_wd_cnt;
    logic [GAP_W-1:0]     r_gap_cnt;

    logic [7:0]           w_req_bytes [NUM_REQ];
    logic                 w_grant_valid;
    logic [IDX_W-1:0]     w_grant_idx;
    logic [IDX_W-1:0]     w_cand;

    // Unpack the flat tx-byte bus into one byte per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_bytes
            assign w_req_bytes[gi] = i_req_data[8*gi +: 8];
        end
    endgenerate

    // Round-robin search starting just after the last winner. Candidates are
    // visited from the farthest offset to the nearest so the nearest set bit
    // is the one that sticks.
    always_comb begin
        int v_pos;
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        v_pos         = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            v_pos = int'(r_ptr) + k;
            if (v_pos >= NUM_REQ) begin
                v_pos = v_pos - NUM_REQ;
            end
            w_cand = IDX_W'(v_pos);
            if (i_req[w_cand]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= PTR_RST;
            r_idx       <= '0;
            r_ack       <= '0;
            r_done      <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_drv_start <= 1'b0;
            r_cs_n      <= '1;
            r_drv_data  <= '0;
            r_rsp_data  <= '0;
            r_wd_cnt    <= '0;
            r_gap_cnt   <= '0;
        end else begin
            // Pulse outputs default low every cycle.
            r_ack       <= '0;
            r_done      <= '0;
            r_err       <= 1'b0;
            r_drv_start <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_idx               <= w_grant_idx;
                        r_ptr               <= w_grant_idx;
                        r_drv_data          <= w_req_bytes[w_grant_idx];
                        r_ack[w_grant_idx]  <= 1'b1;
                        r_busy              <= 1'b1;
                        r_state             <= S_START;
                    end
                end

                S_START: begin
                    r_drv_start   <= 1'b1;
                    r_cs_n[r_idx] <= 1'b0;
                    r_wd_cnt      <= '0;
                    r_state       <= S_WAIT_EN;
                end

                S_WAIT_EN: begin
                    if (r_wd_cnt == WD_LAST) begin
                        r_rsp_data    <= 8'h00;
                        r_done[r_idx] <= 1'b1;
                        r_err         <= 1'b1;
                        r_cs_n        <= '1;
                        r_gap_cnt     <= '0;
                        r_state       <= S_GAP;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                        if (i_drv_en) begin
                            r_state <= S_WAIT_DONE;
                        end
                    end
                end

                S_WAIT_DONE: begin
                    // A genuine completion wins over a coincident timeout.
                    if (!i_drv_en) begin
                        r_rsp_data    <= i_drv_rdata;
                        r_done[r_idx] <= 1'b1;
                        r_cs_n        <= '1;
                        r_gap_cnt     <= '0;
                        r_state       <= S_GAP;
                    end else if (r_wd_cnt == WD_LAST) begin
                        r_rsp_data    <= 8'h00;
                        r_done[r_idx] <= 1'b1;
                        r_err         <= 1'b1;
                        r_cs_n        <= '1;
                        r_gap_cnt     <= '0;
                        r_state       <= S_GAP;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end

                S_GAP: begin
                    // Requests are not looked at here; arbitration resumes in IDLE.
                    if (r_gap_cnt == GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_cs_n  <= '1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ack       = r_ack;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_rsp_data  = r_rsp_data;
    assign o_busy      = r_busy;
    assign o_cs_n      = r_cs_n;
    assign o_drv_start = r_drv_start;
    assign o_drv_data  = r_drv_data;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_txn_arbiter
// Table-driven bench for spi_txn_arbiter (NUM_REQ=4, GAP_CYCLES=2,
// WDOG_CYCLES=64) with a simple SPI driver model, followed by hand-written
// sequences for watchdog abort, reset mid-transaction and a request pulse
// during the inter-transaction gap.
// ---------------------------------------------------------------------------
module tb_spi_txn_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        err;
    logic [7:0]  rsp_data;
    logic        busy;
    logic [3:0]  cs_n;
    logic        drv_start;
    logic [7:0]  drv_data;
    logic        drv_en;
    logic [7:0]  drv_rdata;

    int tests = 0;
    int fails = 0;

    // Driver model controls
    logic        model_on;
    logic [7:0]  model_xor;
    int          m_cnt;

    always #5 clk = ~clk;

    spi_txn_arbiter #(
        .NUM_REQ     (4),
        .GAP_CYCLES  (2),
        .WDOG_CYCLES (64)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_req_data  (req_data),
        .o_ack       (ack),
        .o_done      (done),
        .o_err       (err),
        .o_rsp_data  (rsp_data),
        .o_busy      (busy),
        .o_cs_n      (cs_n),
        .o_drv_start (drv_start),
        .o_drv_data  (drv_data),
        .i_drv_en    (drv_en),
        .i_drv_rdata (drv_rdata)
    );

    // SPI driver model: one cycle after seeing start, raise enable for eight
    // bit-times, then drop it and present the looped-back byte (optionally
    // XOR-scrambled so the response differs from the tx byte).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt     <= 0;
            drv_en    <= 1'b0;
            drv_rdata <= 8'h00;
        end else if (m_cnt == 0) begin
            if (drv_start && model_on) m_cnt <= 1;
        end else if (m_cnt == 9) begin
            drv_en    <= 1'b0;
            drv_rdata <= drv_data ^ model_xor;
            m_cnt     <= 0;
        end else begin
            if (m_cnt == 1) begin
                drv_en    <= 1'b1;
                drv_rdata <= 8'hEE;
            end
            m_cnt <= m_cnt + 1;
        end
    end

    typedef struct {
        logic [3:0] req;
        logic [7:0] mxor;
        logic [3:0] exp_ack;
        logic [7:0] exp_data;
        logic [7:0] exp_rsp;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int n);
        vec_t       v;
        int         lat;
        int         cyc;
        bit         cs_ok;
        logic [3:0] exp_cs;
        v      = vecs[n];
        exp_cs = ~v.exp_ack;
        req       = v.req;
        model_xor = v.mxor;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (ack == 4'h0 && lat < 20);
        check("ack_onehot", {28'b0, ack}, {28'b0, v.exp_ack});
        check("ack_latency", lat, 1);
        tick();
        check("drv_start", {31'b0, drv_start}, 1);
        check("drv_data", {24'b0, drv_data}, {24'b0, v.exp_data});
        check("cs_start", {28'b0, cs_n}, {28'b0, exp_cs});
        cs_ok = 1'b1;
        cyc   = 0;
        do begin
            tick();
            cyc++;
            if (done == 4'h0 && (cs_n !== exp_cs || drv_start !== 1'b0)) cs_ok = 1'b0;
        end while (done == 4'h0 && cyc < 100);
        check("cs_hold", {31'b0, cs_ok}, 1);
        check("done_onehot", {28'b0, done}, {28'b0, v.exp_ack});
        check("err_clear", {31'b0, err}, 0);
        check("rsp_data", {24'b0, rsp_data}, {24'b0, v.exp_rsp});
        check("cs_gap0", {28'b0, cs_n}, 32'hF);
        tick();
        check("done_pulse", {28'b0, done}, 0);
        check("cs_gap1", {28'b0, cs_n}, 32'hF);
        tick();
        check("busy_idle", {31'b0, busy}, 0);
        $display("[TB] txn %0d req=%b grant=%b drv_data=%h rsp=%h", n, v.req, v.exp_ack, v.exp_data, rsp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int  lat;
        int  cyc;
        bit  ack_seen;

        // Round-robin with all requesters held, then a single request,
        // then priority rotation after requester 3 is served.
        vecs[0]  = '{4'hF, 8'h5A, 4'h1, 8'h3C, 8'h66};
        vecs[1]  = '{4'hF, 8'h5A, 4'h2, 8'h96, 8'hCC};
        vecs[2]  = '{4'hF, 8'h5A, 4'h4, 8'hA5, 8'hFF};
        vecs[3]  = '{4'hF, 8'h5A, 4'h8, 8'hF0, 8'hAA};
        vecs[4]  = '{4'hF, 8'h5A, 4'h1, 8'h3C, 8'h66};
        vecs[5]  = '{4'hF, 8'h5A, 4'h2, 8'h96, 8'hCC};
        vecs[6]  = '{4'hF, 8'h5A, 4'h4, 8'hA5, 8'hFF};
        vecs[7]  = '{4'hF, 8'h5A, 4'h8, 8'hF0, 8'hAA};
        vecs[8]  = '{4'h4, 8'h00, 4'h4, 8'hA5, 8'hA5};
        vecs[9]  = '{4'h8, 8'hFF, 4'h8, 8'hF0, 8'h0F};
        vecs[10] = '{4'h9, 8'hFF, 4'h1, 8'h3C, 8'hC3};
        vecs[11] = '{4'h9, 8'hFF, 4'h8, 8'hF0, 8'h0F};

        rst       = 1'b1;
        req       = 4'h0;
        req_data  = {8'hF0, 8'hA5, 8'h96, 8'h3C};
        model_on  = 1'b1;
        model_xor = 8'h00;
        tick();
        tick();
        tick();

        // Reset state
        check("rst_cs_n", {28'b0, cs_n}, 32'hF);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_ack", {28'b0, ack}, 0);
        check("rst_done", {28'b0, done}, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_drv_start", {31'b0, drv_start}, 0);
        check("rst_drv_data", {24'b0, drv_data}, 0);
        check("rst_rsp_data", {24'b0, rsp_data}, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", {31'b0, busy}, 0);

        for (int i = 0; i < 12; i++) begin
            run_vec(i);
        end

        // Watchdog: driver never raises enable; requester 1 is next.
        model_on = 1'b0;
        req      = 4'b0010;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (ack == 4'h0 && lat < 20);
        check("wd_ack", {28'b0, ack}, 32'h2);
        req = 4'h0;
        tick();
        check("wd_drv_start", {31'b0, drv_start}, 1);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (done == 4'h0 && cyc < 200);
        check("wd_cycles", cyc, 64);
        check("wd_done", {28'b0, done}, 32'h2);
        check("wd_err", {31'b0, err}, 1);
        check("wd_rsp", {24'b0, rsp_data}, 0);
        check("wd_cs_n", {28'b0, cs_n}, 32'hF);
        tick();
        check("wd_err_pulse", {31'b0, err}, 0);
        tick();
        check("wd_busy_idle", {31'b0, busy}, 0);
        $display("[TB] txn wdog grant=0010 cycles=%0d rsp=%h", cyc, rsp_data);

        // Reset while requester 1 is in the middle of a transfer.
        model_on  = 1'b1;
        model_xor = 8'h00;
        req       = 4'b0010;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (ack == 4'h0 && lat < 20);
        check("mr_ack", {28'b0, ack}, 32'h2);
        tick();
        check("mr_cs_active", {28'b0, cs_n}, 32'hD);
        repeat (5) tick();
        check("mr_drv_en", {31'b0, drv_en}, 1);
        rst = 1'b1;
        #1;
        check("mr_async_cs_n", {28'b0, cs_n}, 32'hF);
        check("mr_async_busy", {31'b0, busy}, 0);
        check("mr_async_done", {28'b0, done}, 0);
        ack_seen = 1'b0;
        repeat (2) begin
            tick();
            if (done != 4'h0 || ack != 4'h0) ack_seen = 1'b1;
        end
        check("mr_quiet", {31'b0, ack_seen}, 0);
        rst = 1'b0;
        tick();
        check("mr_reack", {28'b0, ack}, 32'h2);
        req = 4'h0;
        tick();
        check("mr_restart", {31'b0, drv_start}, 1);
        check("mr_drv_data", {24'b0, drv_data}, 32'h96);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (done == 4'h0 && cyc < 100);
        check("mr_done", {28'b0, done}, 32'h2);
        check("mr_rsp", {24'b0, rsp_data}, 32'h96);
        $display("[TB] txn reset-retry grant=0010 rsp=%h", rsp_data);

        // Request pulse on requester 0 while in the gap.
        req = 4'b0001;
        tick();
        req = 4'h0;
        check("ld_no_ack0", {28'b0, ack}, 0);
        tick();
        check("ld_busy_idle", {31'b0, busy}, 0);
        ack_seen = 1'b0;
        repeat (4) begin
            tick();
            if (ack != 4'h0 || busy != 1'b0) ack_seen = 1'b1;
        end
        check("ld_stay_idle", {31'b0, ack_seen}, 0);
        $display("[TB] txn late-drop req=0001 ack_seen=%0d", ack_seen);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
